// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: byte FIFO in the UART echo path (clk12 domain).
// Takes bytes from uart_rx through the rxvalid/rxack handshake, buffers up
// to 2^DEPTH_LOG2 bytes, and feeds uart_tx through tx_start/tx_busy.
// Optional feature macro: UART_ECHO_FIFO_DROP_EN
//   defined     : a byte offered while full is acknowledged and discarded,
//                 and the sticky overflow flag is set.
//   not defined : a byte offered while full is held off (no rxack) until
//                 space exists; overflow is constant 0.
`timescale 1ns/1ps

module uart_echo_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rxdata,
    input  logic                  rxvalid,
    output logic                  rxack,
    output logic [7:0]            txdata,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = (DEPTH_LOG2+1)'(1'b0);
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = CNT_ONE << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = (DEPTH_LOG2)'(1'b0);

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_ACK  = 2'd1,
        RX_WAIT = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    rx_state_t              rx_state_r;
    tx_state_t              tx_state_r;
    logic [DEPTH_LOG2-1:0]  wp_r;
    logic [DEPTH_LOG2-1:0]  rp_r;
    logic [7:0]             mem_r [DEPTH];

    logic                   full_s;
    logic                   empty_s;
    logic                   wr_s;
    logic                   rd_s;
`ifdef UART_ECHO_FIFO_DROP_EN
    logic                   drop_s;
`endif

    // Decode this edge's FIFO write/read (and drop) from FSM states and occupancy
    always_comb begin
        full_s  = (count == FULL_COUNT);
        empty_s = (count == CNT_ZERO);
        wr_s    = (rx_state_r == RX_IDLE) && rxvalid && !full_s;
        rd_s    = (tx_state_r == TX_IDLE) && !empty_s && !tx_busy;
`ifdef UART_ECHO_FIFO_DROP_EN
        drop_s  = (rx_state_r == RX_IDLE) && rxvalid && full_s;
`endif
    end

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wp_r] <= rxdata;
        end
    end

    // Occupancy: a write and a read on the same edge cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else begin
            case ({wr_s, rd_s})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // RX handshake FSM: accept one byte per rxvalid assertion, pulse rxack once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rxack      <= 1'b0;
            wp_r       <= PTR_ZERO;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (wr_s) begin
                        wp_r       <= wp_r + PTR_ONE;
                        rxack      <= 1'b1;
                        rx_state_r <= RX_ACK;
`ifdef UART_ECHO_FIFO_DROP_EN
                    end else if (drop_s) begin
                        // Byte is acknowledged but not stored
                        rxack      <= 1'b1;
                        rx_state_r <= RX_ACK;
`endif
                    end else begin
                        rxack      <= 1'b0;
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_ACK: begin
                    rxack      <= 1'b0;
                    rx_state_r <= RX_WAIT;
                end
                RX_WAIT: begin
                    rxack <= 1'b0;
                    // Wait for the receiver to drop rxvalid so one byte is never written twice
                    if (!rxvalid) begin
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_state_r <= RX_WAIT;
                    end
                end
                default: begin
                    rxack      <= 1'b0;
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // TX handshake FSM: pop one byte, hold tx_start until the transmitter goes busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_start   <= 1'b0;
            txdata     <= 8'h00;
            rp_r       <= PTR_ZERO;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (rd_s) begin
                        txdata     <= mem_r[rp_r];
                        rp_r       <= rp_r + PTR_ONE;
                        tx_start   <= 1'b1;
                        tx_state_r <= TX_START;
                    end else begin
                        tx_start   <= 1'b0;
                        tx_state_r <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_busy) begin
                        tx_start   <= 1'b0;
                        tx_state_r <= TX_WAIT;
                    end else begin
                        tx_start   <= 1'b1;
                        tx_state_r <= TX_START;
                    end
                end
                TX_WAIT: begin
                    tx_start <= 1'b0;
                    // txdata stays put until the transmitter has finished with it
                    if (!tx_busy) begin
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_state_r <= TX_WAIT;
                    end
                end
                default: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_ECHO_FIFO_DROP_EN
    // Sticky record that a byte was discarded while full; cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else begin
            overflow <= overflow;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Byte FIFO between the UART receiver and the UART transmitter in the echo path. Consumes bytes from `uart_rx` via its `rxvalid`/`rxack` handshake, buffers up to 2^DEPTH_LOG2 bytes, and drives `uart_tx` via `tx_start`/`tx_busy`. This lets back-to-back received bytes survive while the transmitter is busy. Runs entirely in the 12 MHz UART clock domain.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..8.
- `clk`  in  1  UART clock (clk12); all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rxdata`  in  8  received byte from `uart_rx`; stable while `rxvalid`=1.
- `rxvalid`  in  1  level; byte available, held until acknowledged.
- `rxack`  out  1  registered one-cycle acknowledge to `uart_rx`.
- `txdata`  out  8  registered byte to `uart_tx`; stable from `tx_start` rise until `tx_busy` falls.
- `tx_start`  out  1  registered start request to `uart_tx`.
- `tx_busy`  in  1  transmitter busy level.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 memory, write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits.
  - Pointers wrap modulo depth naturally.
  - `count` is a separate register; empty is `count`==0, full is `count`==2^DEPTH_LOG2.
- Count update per edge: write only gives +1; read only gives -1; write and read in the same edge leave `count` unchanged. This applies at full and at empty.
- RX FSM (states RX_IDLE, RX_ACK, RX_WAIT):
  - RX_IDLE with `rxvalid`=1 and not full: write `rxdata` at `wp`, increment `wp`, set `rxack`=1, go to RX_ACK.
  - RX_IDLE with `rxvalid`=1 and full: behaviour depends on the Configuration macro.
  - RX_ACK: `rxack` returns to 0; go to RX_WAIT.
  - RX_WAIT: stay until `rxvalid`=0, then go to RX_IDLE. This prevents a double write of one byte.
- TX FSM (states TX_IDLE, TX_START, TX_WAIT):
  - TX_IDLE with not empty and `tx_busy`=0: `txdata`<=mem[`rp`], increment `rp`, `tx_start`<=1, go to TX_START.
  - TX_START: hold `tx_start`=1 until `tx_busy`=1 is sampled. On that edge `tx_start`<=0 and go to TX_WAIT.
  - TX_WAIT: stay until `tx_busy`=0, then go to TX_IDLE.
- A write and a read at the same address in the same edge cannot occur while `count` < depth. The read uses the pre-edge memory contents.

## Timing
- Reset values:
  - `rxack`=0, `tx_start`=0, `txdata`=8'h00, `count`=0, `overflow`=0.
  - Pointers 0; both FSMs idle.
  - FIFO contents are don't-care.
- Reset mid-operation: all buffered bytes are discarded. `tx_start` and `rxack` drop asynchronously.
- Write latency: `rxvalid` sampled high at edge N (RX_IDLE, not full) gives `rxack`=1 and `count`+1 after edge N. `rxack`=0 after edge N+1.
- Echo latency with an empty FIFO and idle transmitter: `tx_start`=1 after edge N+1. `txdata` is valid in the same cycle.
- `tx_start` stays high for at least 1 cycle. It falls on the edge that samples `tx_busy`=1.
- Next `tx_start` no earlier than 1 cycle after `tx_busy` is sampled 0.

## Configuration
- `UART_ECHO_FIFO_DROP_EN` defined:
  - `rxvalid`=1 while full: `rxack` is still pulsed and the byte is discarded.
  - `wp` and `count` are unchanged; `overflow`<=1 (sticky until `rst`).
  - RX FSM goes to RX_ACK as normal.
- Not defined:
  - While full, the RX FSM stays in RX_IDLE with `rxack`=0. This applies backpressure to `uart_rx`.
  - The byte is written on the first edge where space exists.
  - `overflow` is tied to 0.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Require all outputs at reset values immediately, and `count`=0 after release.
- Single echo: `rxdata`=8'hA5 with `rxvalid` held until one cycle after `rxack`, `tx_busy` model idle. Require `rxack` pulse of exactly 1 cycle, `tx_start`=1 two edges after `rxvalid` is sampled, `txdata`=8'hA5, and exactly one byte sent.
- Burst with busy transmitter: hold `tx_busy`=1 and push 8'h01..8'h10 (16 bytes, DEPTH_LOG2=4). Require `count`=16, then release `tx_busy`. Require transmit order 01..10, `count` reaching 0, and `overflow`=0.
- Overflow with DROP_EN defined: fill to 16, then push 8'hEE. Require `rxack` pulse, `count`=16, `overflow`=1, and 8'hEE never transmitted.
- Overflow without DROP_EN: same stimulus. Require no `rxack` while full; after one byte drains, require 8'hEE written and transmitted last.
- Simultaneous read and write: with `count`=3, time an `rxvalid` accept on the same edge as a TX pop. Require `count` to stay 3 and no byte lost or duplicated across wrap of `wp`/`rp` (run 40 bytes).
